// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register word, register index, and the
// register-file dump engine state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    DONE    = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dump_engine.sv
// Walks register indices over the register file's read port 1 and streams
// (index, value) pairs on a valid/ready port, summing every accepted word.
module regfile_dump_engine
  import cpu_types_pkg::*;
#(
  parameter int NREGS   = 32,
  parameter int SKIP_R0 = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  output regbits_t    rsel1,
  input  word_t       rdat1,
  output logic        out_valid,
  input  logic        out_ready,
  output regbits_t    out_idx,
  output word_t       out_data,
  output logic        busy,
  output logic        done,
  output word_t       checksum,
  output dump_state_t dbg_state
);

  localparam int       FIRST_I = (SKIP_R0 != 0) ? 1 : 0;
  localparam regbits_t FIRST   = regbits_t'(FIRST_I);
  localparam regbits_t LAST    = regbits_t'(NREGS - 1);

  if (!(FIRST_I < NREGS && NREGS <= 32)) begin : g_bad_nregs
    $error("regfile_dump_engine: NREGS must satisfy FIRST < NREGS <= 32");
  end

  // Output handshake: a word transfers at a rising edge where
  // out_valid && out_ready; while out_valid is high and out_ready is low,
  // out_idx/out_data are held unchanged.

  dump_state_t state, state_n;
  regbits_t    idx, idx_n;
  logic        valid_n;
  regbits_t    oidx_n;
  word_t       odata_n;
  word_t       sum_n;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= FIRST;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      checksum  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      out_valid <= valid_n;
      out_idx   <= oidx_n;
      out_data  <= odata_n;
      checksum  <= sum_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    valid_n = out_valid;
    oidx_n  = out_idx;
    odata_n = out_data;
    sum_n   = checksum;
    busy    = (state != IDLE);
    done    = (state == DONE);
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = READ;
          idx_n   = FIRST;
          sum_n   = '0;
        end
      end
      // The register file samples rsel1 at the end of this cycle.
      READ: state_n = CAPTURE;
      CAPTURE: begin
        odata_n = rdat1;
        oidx_n  = idx;
        valid_n = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        if (out_ready) begin
          sum_n   = checksum + out_data;
          valid_n = 1'b0;
          if (idx == LAST) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + 5'd1;
            state_n = READ;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rsel1     = idx;
  assign dbg_state = state;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Bench for regfile_dump_engine: two instances (SKIP_R0=1 and 0) share a
// behavioural register file with a one-cycle registered read.
module tb_regfile_dump_engine;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic RST;
  logic start_cmd;
  logic use_skip;
  logic out_ready;

  logic [31:0] regs [32];

  regbits_t    rsel_s, rsel_f, idx_s, idx_f;
  word_t       rdat_s, rdat_f, data_s, data_f, sum_s, sum_f;
  logic        valid_s, valid_f, busy_s, busy_f, done_s, done_f;
  dump_state_t st_s, st_f;

  always @(posedge clk) begin
    rdat_s <= regs[rsel_s];
    rdat_f <= regs[rsel_f];
  end

  regfile_dump_engine #(.NREGS(32), .SKIP_R0(1)) u_skip (
    .CLK(clk), .RST(RST), .start(start_cmd & use_skip),
    .rsel1(rsel_s), .rdat1(rdat_s),
    .out_valid(valid_s), .out_ready(out_ready), .out_idx(idx_s), .out_data(data_s),
    .busy(busy_s), .done(done_s), .checksum(sum_s), .dbg_state(st_s)
  );

  regfile_dump_engine #(.NREGS(32), .SKIP_R0(0)) u_full (
    .CLK(clk), .RST(RST), .start(start_cmd & ~use_skip),
    .rsel1(rsel_f), .rdat1(rdat_f),
    .out_valid(valid_f), .out_ready(out_ready), .out_idx(idx_f), .out_data(data_f),
    .busy(busy_f), .done(done_f), .checksum(sum_f), .dbg_state(st_f)
  );

  logic        m_valid, m_busy, m_done;
  regbits_t    m_idx;
  word_t       m_data, m_sum;
  dump_state_t m_state;
  assign m_valid = use_skip ? valid_s : valid_f;
  assign m_busy  = use_skip ? busy_s  : busy_f;
  assign m_done  = use_skip ? done_s  : done_f;
  assign m_idx   = use_skip ? idx_s   : idx_f;
  assign m_data  = use_skip ? data_s  : data_f;
  assign m_sum   = use_skip ? sum_s   : sum_f;
  assign m_state = use_skip ? st_s    : st_f;

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [36:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_val(input bit sparse, input int i);
    if (sparse) return (i == 5) ? 32'hDEADBEEF : 32'h0;
    return 32'(i) * 32'h11;
  endfunction

  typedef struct {
    bit          skip;
    bit          sparse;
    int          stall_idx;
    int          restart_idx;
    int          exp_words;
    logic [31:0] exp_sum;
  } scen_t;

  scen_t tbl[5];

  // ---------------- driver tasks ----------------
  task automatic preload(input bit sparse);
    for (int i = 0; i < 32; i++) regs[i] = exp_val(sparse, i);
  endtask

  task automatic run_scen(input scen_t s, input string tag);
    int cyc = 0, first_valid = -1, done_cnt = 0, words = 0, stall_cnt = 0;
    int post = -1;
    bit restarted = 0, finished = 0, busy_late = 0, hold_pend = 0;
    use_skip = s.skip;
    preload(s.sparse);
    exp_q.delete();
    for (int i = (s.skip ? 1 : 0); i < 32; i++) exp_q.push_back({5'(i), exp_val(s.sparse, i)});
    @(posedge clk); #1;
    start_cmd = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    for (int k = 0; k < 250 && !finished; k++) begin
      @(negedge clk);
      cyc++;
      if (hold_pend && exp_q.size() > 0)
        check({tag, "_stall_hold"}, {m_valid, m_idx, m_data}, {1'b1, exp_q[0]});
      hold_pend = 0;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (m_done) done_cnt++;
      if (post >= 0) begin
        post++;
        if (post == 1) check({tag, "_busy_after_done"}, m_busy, 1'b0);
        if (m_busy) busy_late = 1;
        if (post == 8) finished = 1;
      end else if (m_done) begin
        post = 0;
      end
      if (m_valid && out_ready) begin
        words++;
        if (exp_q.size() > 0) check({tag, "_word"}, {m_idx, m_data}, exp_q.pop_front());
      end
      if (m_valid && !out_ready) hold_pend = 1;
      @(posedge clk); #1;
      start_cmd = 1'b0;
      if (s.stall_idx >= 0 && m_valid && int'(m_idx) == s.stall_idx && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      if (s.restart_idx >= 0 && !restarted && m_valid && int'(m_idx) == s.restart_idx) begin
        start_cmd = 1'b1;
        restarted = 1;
      end
    end
    if (!finished) check({tag, "_timeout"}, 64'd0, 64'd1);
    check({tag, "_first_valid_cyc"}, 64'(first_valid), 64'd3);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_word_count"}, 64'(words), 64'(s.exp_words));
    check({tag, "_missing_words"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_checksum"}, m_sum, s.exp_sum);
    check({tag, "_busy_late"}, busy_late, 1'b0);
    if (s.stall_idx >= 0) check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd5);
    if (s.restart_idx >= 0) check({tag, "_restart_issued"}, restarted, 1'b1);
  endtask

  task automatic reset_mid_dump();
    bit found = 0;
    int done_cnt = 0;
    use_skip = 1'b1;
    preload(1'b0);
    @(posedge clk); #1;
    start_cmd = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start_cmd = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk); #1;
      if (valid_s && idx_s == 5'd12) found = 1;
    end
    check("rst_reached_idx12", found, 1'b1);
    check("rst_pre_checksum", sum_s, 32'h462);
    out_ready = 1'b0;
    RST = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_state", st_s, IDLE);
    check("rst_valid", valid_s, 1'b0);
    check("rst_checksum", sum_s, 32'h0);
    check("rst_busy", busy_s, 1'b0);
    check("rst_rsel", rsel_s, 5'd1);
    for (int k = 0; k < 6; k++) begin
      if (done_s) done_cnt++;
      @(negedge clk);
    end
    check("rst_no_done", 64'(done_cnt), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    RST = 1'b1;
    start_cmd = 1'b0;
    use_skip = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {st_s, st_f}, {IDLE, IDLE});
    check("reset_rsel_skip", rsel_s, 5'd1);
    check("reset_rsel_full", rsel_f, 5'd0);
    check("reset_outputs", {valid_s, valid_f, idx_s, idx_f, data_s, data_f}, '0);
    check("reset_status", {busy_s, busy_f, done_s, done_f}, 4'b0);
    check("reset_checksum", {sum_s, sum_f}, 64'd0);
    @(posedge clk); #1;
    RST = 1'b0;

    tbl[0] = '{1'b1, 1'b0, -1, -1, 31, 32'h000020F0};
    tbl[1] = '{1'b0, 1'b0, -1, -1, 32, 32'h000020F0};
    tbl[2] = '{1'b1, 1'b0,  7, -1, 31, 32'h000020F0};
    tbl[3] = '{1'b1, 1'b0, -1, 10, 31, 32'h000020F0};
    tbl[4] = '{1'b1, 1'b1, -1, -1, 31, 32'hDEADBEEF};

    for (int t = 0; t < 5; t++) run_scen(tbl[t], $sformatf("scen%0d", t));

    reset_mid_dump();
    run_scen(tbl[0], "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_dump_engine.md
Name: regfile_dump_engine

Overview:
- Read-side initiator for the register file's read port. It walks register indices in order over rsel1/rdat1 and streams each (index, value) pair out on a valid/ready port.
- Accounts for the register file's one-cycle registered read latency.
- Used at halt to dump architectural state to the testbench or memory-writer logic.
- Accumulates a 32-bit wrapping checksum of all dumped words.

Parameters:
- NREGS, 32: number of registers walked; the last index is NREGS-1.
- SKIP_R0, 1: when 1, the dump starts at index 1 (r0 is hardwired zero); when 0, it starts at index 0.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- start  in  1  request a dump; sampled only in IDLE.
- rsel1  out  5  read select driven to the register file read port 1.
- rdat1  in  32  registered read data from the register file; valid one cycle after rsel1 is applied.
- out_valid  out  1  out_idx/out_data hold a dumped word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready at a rising edge.
- out_idx  out  5  register index of out_data.
- out_data  out  32  dumped register value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last word is accepted.
- checksum  out  32  wrapping sum of all words accepted in the current or most recent dump.

Behaviour:
- Reset (RST high at an edge): state=IDLE, idx=FIRST (FIRST = SKIP_R0 ? 1 : 0), rsel1=FIRST, out_valid=0, out_idx=0, out_data=0, busy=0, done=0, checksum=0. Reset wins over every other event, including mid-dump; the dump is abandoned with no done pulse.
- rsel1 is driven combinationally from the idx register at all times. The engine never drives WEN/wsel/wdat.
- States: IDLE, READ, CAPTURE, SEND, DONE.
- IDLE: on start=1 -> READ, idx<=FIRST, checksum<=0. start=0 stays in IDLE. checksum holds its last value in IDLE.
- READ: rsel1=idx; the register file samples it at this edge. Unconditionally -> CAPTURE.
- CAPTURE: rdat1 now holds regfile[idx]. At the edge: out_data<=rdat1, out_idx<=idx, out_valid<=1, -> SEND.
- SEND: out_valid=1, and out_data/out_idx are stable until accepted. On out_ready:
  - checksum<=checksum+out_data (mod 2^32) and out_valid<=0.
  - If idx==NREGS-1 -> DONE; else idx<=idx+1 -> READ.
  - out_ready=0 holds SEND indefinitely with no change.
- DONE: done=1 for exactly this cycle, busy=1. -> IDLE.
- start while busy is ignored and does not queue.
- Timing:
  - Start sampled at edge E0: READ during E0..E1, CAPTURE during E1..E2, out_valid visible after E2.
  - With out_ready held high, throughput is one word per 3 cycles.
  - Full dump with SKIP_R0=1 and ready always high: 31 words, done after 93 cycles in READ/CAPTURE/SEND.
- A register write to the same index in the READ cycle is not visible: the register file returns the pre-write value. The engine does not guard against writes during a dump; the caller guarantees quiescence (halted pipeline).
- Boundaries:
  - idx never wraps: NREGS-1 terminates the dump.
  - NREGS must satisfy FIRST < NREGS <= 32; other values are illegal configurations (elaboration assertion).

Decomposition:
- cpu_types_pkg: reuse word_t and regbits_t. Add the dump_state_t enum (IDLE, READ, CAPTURE, SEND, DONE).
- No sub-module; a single FSM + datapath module.

Test Plan:
- Registers preloaded with r[i]=i*0x11, SKIP_R0=1, out_ready=1, pulse start -> 31 words:
  - idx 1..31, data 0x11..0x20F.
  - out_valid first high 3 cycles after the start edge.
  - done pulse once; checksum=0x000020F0; busy low the cycle after done.
- SKIP_R0=0, same preload -> 32 words starting at (idx 0, data 0x0); checksum=0x000020F0.
- Same preload, out_ready low for 5 cycles whenever out_idx==7 -> out_data=0x77 held stable throughout; no word lost or duplicated; checksum still 0x20F0.
- start pulsed again during the dump at idx 10 -> ignored: exactly one done pulse, word count 31.
- RST asserted while in SEND at idx 12 -> next cycle IDLE, out_valid=0, checksum=0, no done pulse. A new start then produces a full correct dump.
- r5=0xDEADBEEF with all other registers zero, SKIP_R0=1 -> out_data=0xDEADBEEF only at out_idx=5; checksum=0xDEADBEEF.
